// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//   Instruction issue unit for simple_cpu. It holds a small writable program
//   store. On start it plays the store out in address order. Each word is held
//   on the instruction output for HOLD_CYCLES clocks, which matches the CPU's
//   multi-cycle execute. Playback stops on a HALT word (top two bits 2'b00) or
//   at the last store address. There is no wrap-around.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active low
//   prog_we      in   program store write enable (ignored while busy)
//   prog_addr    in   program store write address
//   prog_data    in   program store write data
//   start        in   begin playback from address 0 (ignored while busy)
//   instruction  out  registered instruction word; 0 when not issuing
//   instr_valid  out  1 while instruction carries a program word
//   pc           out  index of the word currently or last issued
//   busy         out  1 while playback is in progress (HOLD)
//   done         out  1 after playback ends, until the next start or reset
//   state_dbg    out  raw FSM state encoding, for checkers and debug
//
// Handshake: there is no ready/valid back-pressure. start and prog_we are
// sampled at a rising edge only while busy is 0. While busy is 1 they are
// dropped silently. instr_valid qualifies instruction on every cycle.
// -----------------------------------------------------------------------------
module instr_sequencer #(
  parameter int INSTR_WIDTH    = 20,
  parameter int PROG_ADDR_BITS = 4,
  parameter int HOLD_CYCLES    = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      prog_we,
  input  logic [PROG_ADDR_BITS-1:0] prog_addr,
  input  logic [INSTR_WIDTH-1:0]    prog_data,
  input  logic                      start,
  output logic [INSTR_WIDTH-1:0]    instruction,
  output logic                      instr_valid,
  output logic [PROG_ADDR_BITS-1:0] pc,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                state_dbg
);

  localparam int DEPTH = 2 ** PROG_ADDR_BITS;
  // The hold counter needs at least one bit, even when HOLD_CYCLES is 1.
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [CNT_W-1:0]          CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]          CNT_ONE  = CNT_W'(1);
  localparam logic [PROG_ADDR_BITS-1:0] PC_ONE   = PROG_ADDR_BITS'(1);
  localparam logic [PROG_ADDR_BITS-1:0] PC_LAST  = PROG_ADDR_BITS'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [INSTR_WIDTH-1:0]      instr_q, instr_d;
  logic                        valid_q, valid_d;
  logic [PROG_ADDR_BITS-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  // The program store is plain registers. Reset does not clear it, so a
  // program survives a reset and can be replayed afterwards.
  logic [INSTR_WIDTH-1:0]      mem_q [DEPTH];

  logic [PROG_ADDR_BITS-1:0]   pc_inc;
  logic [INSTR_WIDTH-1:0]      word0;
  logic [INSTR_WIDTH-1:0]      word_next;
  logic                        store_we;

  function automatic logic is_halt(input logic [INSTR_WIDTH-1:0] w);
    return (w[INSTR_WIDTH-1 -: 2] == 2'b00);
  endfunction

  assign pc_inc    = pc_q + PC_ONE;
  assign word0     = mem_q[0];
  // When pc_q is the last address, pc_inc wraps to 0. The end-of-store test
  // in the FSM runs first, so that wrapped read is never used.
  assign word_next = mem_q[pc_inc];
  assign store_we  = prog_we && (state_q != ST_HOLD);

  // Store write. A write and a start on the same edge is legal: start reads
  // mem_q as it was before the edge, because word0 comes from the old value.
  always_ff @(posedge clk) begin
    if (store_we) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      valid_q <= 1'b0;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    valid_d = valid_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          pc_d  = '0;
          cnt_d = '0;
          if (is_halt(word0)) begin
            // An empty program goes straight to DONE. It never asserts valid.
            state_d = ST_DONE;
            instr_d = '0;
            valid_d = 1'b0;
          end else begin
            state_d = ST_HOLD;
            instr_d = word0;
            valid_d = 1'b1;
          end
        end
      end

      ST_HOLD: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if ((pc_q == PC_LAST) || is_halt(word_next)) begin
            // pc keeps pointing at the last word that was issued.
            state_d = ST_DONE;
            instr_d = '0;
            valid_d = 1'b0;
          end else begin
            instr_d = word_next;
            pc_d    = pc_inc;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        instr_d = '0;
        valid_d = 1'b0;
        pc_d    = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign busy        = (state_q == ST_HOLD);
  assign done        = (state_q == ST_DONE);
  assign state_dbg   = state_q;

endmodule
